// File: rtl/xadc_drp_reader.sv
// rtl/xadc_drp_reader.sv - XADC DRP read sequencer; XADC_DRP_READER_TIMEOUT_EN adds a drdy watchdog
`timescale 1ns/1ps
module xadc_drp_reader #(
    parameter int                        NUM_CHANNELS  = 2,
    parameter logic [NUM_CHANNELS*7-1:0] CHANNEL_ADDRS = {7'h1C, 7'h14},
    parameter int                        DRDY_TIMEOUT  = 64,
    parameter int                        CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic            dclk_in,
    input  logic            reset_in,
    input  logic            eos_in,
    output logic [6:0]      daddr_out,
    output logic            den_out,
    output logic            dwe_out,
    output logic [15:0]     di_out,
    input  logic            drdy_in,
    input  logic [15:0]     do_in,
    output logic            sample_valid_out,
    input  logic            sample_ready_in,
    output logic [15:0]     sample_data_out,
    output logic [CH_W-1:0] sample_channel_out,
    output logic            sample_last_out,
    output logic            busy_out,
    output logic [7:0]      overrun_count_out,
    output logic            timeout_err_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DRDY, PRESENT} state_t;

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CHANNELS - 1);

    state_t          state;
    logic [CH_W-1:0] index;

    function automatic logic [6:0] addr_of(input logic [CH_W-1:0] i);
        return CHANNEL_ADDRS[7*i +: 7];
    endfunction

    assign dwe_out  = 1'b0;
    assign di_out   = 16'h0000;
    assign busy_out = (state != IDLE);

`ifdef XADC_DRP_READER_TIMEOUT_EN
    localparam int TO_W = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRDY_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_err_out = 1'b0;
`endif

    always_ff @(posedge dclk_in) begin
        if (reset_in) begin
            state              <= IDLE;
            index              <= '0;
            daddr_out          <= 7'h00;
            den_out            <= 1'b0;
            sample_valid_out   <= 1'b0;
            sample_data_out    <= 16'h0000;
            sample_channel_out <= '0;
            sample_last_out    <= 1'b0;
            overrun_count_out  <= 8'h00;
`ifdef XADC_DRP_READER_TIMEOUT_EN
            to_cnt             <= '0;
            timeout_err_out    <= 1'b0;
`endif
        end else begin
            den_out <= 1'b0;
`ifdef XADC_DRP_READER_TIMEOUT_EN
            timeout_err_out <= 1'b0;
`endif
            // Includes the cycle in which the last handshake returns us to IDLE.
            if (eos_in && (state != IDLE) && (overrun_count_out != 8'hFF))
                overrun_count_out <= overrun_count_out + 8'd1;

            case (state)
                IDLE: begin
                    if (eos_in) begin
                        index     <= '0;
                        daddr_out <= addr_of('0);
                        den_out   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef XADC_DRP_READER_TIMEOUT_EN
                    to_cnt <= TO_W'(1);
`endif
                    state <= WAIT_DRDY;
                end
                WAIT_DRDY: begin
                    if (drdy_in) begin
                        sample_data_out    <= do_in;
                        sample_channel_out <= index;
                        sample_last_out    <= (index == LAST_IDX);
                        sample_valid_out   <= 1'b1;
                        state              <= PRESENT;
                    end
`ifdef XADC_DRP_READER_TIMEOUT_EN
                    // Abandon the rest of the frame; delivered samples stand.
                    else if (to_cnt >= TO_LAST) begin
                        timeout_err_out <= 1'b1;
                        index           <= '0;
                        state           <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                PRESENT: begin
                    if (sample_ready_in) begin
                        sample_valid_out <= 1'b0;
                        if (sample_last_out) begin
                            state <= IDLE;
                        end else begin
                            index     <= index + CH_W'(1);
                            daddr_out <= addr_of(index + CH_W'(1));
                            den_out   <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
